// File: rtl/pc_gen.sv
// Fetch-address generator: valid/ready PC issue with trap/branch redirects,
// misaligned-branch detection and a BOOT/RUN/HALT control machine.
module pc_gen #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned           INSTR_BYTES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_ready_i,
    input  logic                  trap_valid_i,
    input  logic [DATA_WIDTH-1:0] trap_target_i,
    input  logic                  branch_valid_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    output logic                  flush_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] misalign_addr_o,
    output logic                  halted_o
);

    localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(INSTR_BYTES);
    localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic                    misalign_q, misalign_d;
    logic [DATA_WIDTH-1:0]   misalign_addr_q, misalign_addr_d;

    logic [DATA_WIDTH-1:0]   trap_pc;
    logic [DATA_WIDTH-1:0]   pc_adv;
    logic                    br_misaligned;

    // Trap targets are silently aligned; branch targets are checked instead.
    assign trap_pc       = trap_target_i & ~LOW_MASK;
    assign br_misaligned = |(branch_target_i & LOW_MASK);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_BOOT;
            pc_q            <= RESET_VECTOR;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    // Next-state, next-PC and redirect decode; priority trap > branch > halt > advance.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        flush_o         = 1'b0;
        pc_adv          = pc_ready_i ? (pc_q + STEP) : pc_q;

        case (state_q)
            S_BOOT: begin
                if (trap_valid_i) begin
                    pc_d = trap_pc;
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                if (trap_valid_i) begin
                    pc_d    = trap_pc;
                    flush_o = 1'b1;
                end else if (branch_valid_i && !br_misaligned) begin
                    pc_d    = branch_target_i;
                    flush_o = 1'b1;
                end else if (branch_valid_i) begin
                    pc_d            = pc_adv;
                    misalign_d      = 1'b1;
                    misalign_addr_d = branch_target_i;
                end else if (halt_i) begin
                    pc_d    = pc_adv;
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_adv;
                end
            end
            S_HALT: begin
                if (trap_valid_i) begin
                    pc_d    = trap_pc;
                    flush_o = 1'b1;
                    state_d = S_RUN;
                end else if (resume_i) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = (state_q == S_RUN);
    assign halted_o        = (state_q == S_HALT);
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against a
// behavioural model of the fetch-address rules.
module tb_pc_gen;

    localparam int unsigned IB = 4;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_ready_i = 1'b0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_target_i = '0;
    logic        branch_valid_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        halt_i = 1'b0;
    logic        resume_i = 1'b0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
    logic        halted_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_mode = M_BOOT;
    logic [31:0] m_pc = '0;
    logic        m_mis = 1'b0;
    logic [31:0] m_mis_addr = '0;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .pc_ready_i      (pc_ready_i),
        .trap_valid_i    (trap_valid_i),
        .trap_target_i   (trap_target_i),
        .branch_valid_i  (branch_valid_i),
        .branch_target_i (branch_target_i),
        .halt_i          (halt_i),
        .resume_i        (resume_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o),
        .halted_o        (halted_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] align_down(input logic [31:0] a);
        return (a / IB) * IB;
    endfunction

    function automatic logic model_flush();
        if (m_mode == M_RUN)
            return trap_valid_i || (branch_valid_i && (branch_target_i % IB == 0));
        if (m_mode == M_HALT)
            return trap_valid_i;
        return 1'b0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_next();
        logic [31:0] seq;
        seq = pc_ready_i ? m_pc + IB : m_pc;  // 32-bit sum wraps mod 2^32
        m_mis = 1'b0;
        if (rst) begin
            m_mode = M_BOOT; m_pc = 32'h0; m_mis_addr = '0;
        end else if (m_mode == M_BOOT) begin
            if (trap_valid_i) m_pc = align_down(trap_target_i);
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (trap_valid_i) m_pc = align_down(trap_target_i);
            else if (branch_valid_i && branch_target_i % IB == 0) m_pc = branch_target_i;
            else if (branch_valid_i) begin
                m_pc = seq; m_mis = 1'b1; m_mis_addr = branch_target_i;
            end else if (halt_i) begin
                m_pc = seq; m_mode = M_HALT;
            end else m_pc = seq;
        end else begin
            if (trap_valid_i) begin
                m_pc = align_down(trap_target_i); m_mode = M_RUN;
            end else if (resume_i) m_mode = M_RUN;
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trap_valid_i = 0; branch_valid_i = 0; halt_i = 0; resume_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; pc_ready_i = 1; idle();
        tick(); tick(); tick(); #2;
        total++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || halted_o !== 1'b0 || misalign_o !== 1'b0 || misalign_addr_o !== 32'h0) begin
            bad++; $display("FAIL reset_vals got pc=%h v=%b h=%b m=%b ma=%h", pc_o, pc_valid_o, halted_o, misalign_o, misalign_addr_o); end
        rst = 0; #2;
        total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL boot_bubble got valid=%b exp 0", pc_valid_o); end
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            total++; if (pc_o !== 32'(i * 4) || pc_valid_o !== 1'b1) begin
                bad++; $display("FAIL boot_seq%0d got pc=%h v=%b exp pc=%h v=1", i, pc_o, pc_valid_o, 32'(i * 4)); end
        end
    endtask

    task automatic test_backpressure();
        tick(); tick(); pc_ready_i = 0; #2;
        for (int i = 0; i < 4; i++) begin
            total++; if (pc_o !== 32'h10 || pc_valid_o !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d got pc=%h v=%b exp pc=00000010 v=1", i, pc_o, pc_valid_o); end
            tick(); #2;
        end
        pc_ready_i = 1; tick(); #2;
        total++; if (pc_o !== 32'h14) begin bad++; $display("FAIL bp_resume got pc=%h exp 00000014", pc_o); end
    endtask

    task automatic test_priority();
        trap_valid_i = 1; trap_target_i = 32'h8000_0102;
        branch_valid_i = 1; branch_target_i = 32'h200; #2;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL prio_flush got %b exp 1", flush_o); end
        tick(); idle(); #2;
        total++; if (pc_o !== 32'h8000_0100 || flush_o !== 1'b0) begin
            bad++; $display("FAIL prio_pc got pc=%h f=%b exp pc=80000100 f=0", pc_o, flush_o); end
    endtask

    task automatic test_misalign();
        branch_valid_i = 1; branch_target_i = 32'h40; #2;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL br_flush got %b exp 1", flush_o); end
        tick(); branch_target_i = 32'h202; #2;
        total++; if (pc_o !== 32'h40 || flush_o !== 1'b0) begin
            bad++; $display("FAIL mis_pre got pc=%h f=%b exp pc=00000040 f=0", pc_o, flush_o); end
        tick(); idle(); #2;
        total++; if (pc_o !== 32'h44 || misalign_o !== 1'b1 || misalign_addr_o !== 32'h202) begin
            bad++; $display("FAIL mis_pulse got pc=%h m=%b ma=%h exp 44/1/202", pc_o, misalign_o, misalign_addr_o); end
        tick(); #2;
        total++; if (misalign_o !== 1'b0 || misalign_addr_o !== 32'h202 || pc_o !== 32'h48) begin
            bad++; $display("FAIL mis_once got m=%b ma=%h pc=%h exp 0/202/48", misalign_o, misalign_addr_o, pc_o); end
    endtask

    task automatic test_halt_resume();
        for (int rep = 0; rep < 2; rep++) begin
            branch_valid_i = 1; branch_target_i = 32'h20; tick(); idle();
            pc_ready_i = 0; halt_i = 1; tick(); idle(); #2;
            total++; if (halted_o !== 1'b1 || pc_valid_o !== 1'b0 || pc_o !== 32'h20) begin
                bad++; $display("FAIL halt_enter%0d got h=%b v=%b pc=%h exp 1/0/20", rep, halted_o, pc_valid_o, pc_o); end
            branch_valid_i = 1; branch_target_i = 32'h300; #2;
            total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL halt_br_flush got %b exp 0", flush_o); end
            tick(); idle(); #2;
            total++; if (pc_o !== 32'h20 || halted_o !== 1'b1) begin
                bad++; $display("FAIL halt_br_ign%0d got pc=%h h=%b exp 20/1", rep, pc_o, halted_o); end
            if (rep == 0) begin
                resume_i = 1; tick(); idle(); #2;
                total++; if (pc_o !== 32'h20 || pc_valid_o !== 1'b1 || halted_o !== 1'b0) begin
                    bad++; $display("FAIL resume got pc=%h v=%b h=%b exp 20/1/0", pc_o, pc_valid_o, halted_o); end
            end else begin
                trap_valid_i = 1; trap_target_i = 32'h100; #2;
                total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL halt_trap_flush got %b exp 1", flush_o); end
                tick(); idle(); #2;
                total++; if (pc_o !== 32'h100 || pc_valid_o !== 1'b1) begin
                    bad++; $display("FAIL halt_trap got pc=%h v=%b exp 100/1", pc_o, pc_valid_o); end
            end
        end
        pc_ready_i = 1;
    endtask

    task automatic test_wrap_reset();
        pc_ready_i = 1; branch_valid_i = 1; branch_target_i = 32'hFFFF_FFFC; tick(); idle(); #2;
        total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got %h exp fffffffc", pc_o); end
        tick(); #2;
        total++; if (pc_o !== 32'h0 || misalign_o !== 1'b0 || flush_o !== 1'b0) begin
            bad++; $display("FAIL wrap got pc=%h m=%b f=%b exp 0/0/0", pc_o, misalign_o, flush_o); end
        trap_valid_i = 1; trap_target_i = 32'h500; rst = 1; tick(); rst = 0; idle(); #2;
        total++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || halted_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset got pc=%h v=%b h=%b exp 0/0/0", pc_o, pc_valid_o, halted_o); end
        trap_valid_i = 1; trap_target_i = 32'h604; #2;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL boot_trap_flush got %b exp 0", flush_o); end
        tick(); idle(); #2;
        total++; if (pc_o !== 32'h604 || pc_valid_o !== 1'b1) begin
            bad++; $display("FAIL boot_trap got pc=%h v=%b exp 604/1", pc_o, pc_valid_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            pc_ready_i      = ($urandom_range(0, 3) != 0);
            trap_valid_i    = ($urandom_range(0, 9) == 0);
            trap_target_i   = $urandom;
            branch_valid_i  = ($urandom_range(0, 4) == 0);
            branch_target_i = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            halt_i          = ($urandom_range(0, 11) == 0);
            resume_i        = ($urandom_range(0, 3) == 0);
            #2;
            total++; if (pc_o !== m_pc) begin bad++; $display("FAIL rnd_pc@%0d got %h exp %h", i, pc_o, m_pc); end
            total++; if (pc_valid_o !== (m_mode == M_RUN)) begin bad++; $display("FAIL rnd_valid@%0d got %b", i, pc_valid_o); end
            total++; if (halted_o !== (m_mode == M_HALT)) begin bad++; $display("FAIL rnd_halted@%0d got %b", i, halted_o); end
            total++; if (flush_o !== model_flush()) begin bad++; $display("FAIL rnd_flush@%0d got %b exp %b", i, flush_o, model_flush()); end
            total++; if (misalign_o !== m_mis) begin bad++; $display("FAIL rnd_mis@%0d got %b exp %b", i, misalign_o, m_mis); end
            total++; if (misalign_addr_o !== m_mis_addr) begin bad++; $display("FAIL rnd_misaddr@%0d got %h exp %h", i, misalign_addr_o, m_mis_addr); end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_priority();
        test_misalign();
        test_halt_resume();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the Fetch stage. It replaces the plain enable-gated PC register with a valid/ready handshake toward instruction fetch, prioritised trap and branch redirects, misaligned-target detection, and a halt/resume state machine. It sits at the head of the Fetch stage, feeding instruction memory and the IF/ID pipeline register.

## Interface
- DATA_WIDTH, 32, PC width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (DATA_WIDTH bits)
- INSTR_BYTES, 4, sequential increment and alignment granule; must be a power of two, 2 or 4
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- pc_ready_i  input  1  fetch accepts the presented PC this cycle
- trap_valid_i  input  1  trap/exception redirect request
- trap_target_i  input  DATA_WIDTH  trap handler address
- branch_valid_i  input  1  resolved taken branch/jump redirect request
- branch_target_i  input  DATA_WIDTH  branch/jump target address
- halt_i  input  1  request to stop issuing PCs
- resume_i  input  1  leave HALT at the held PC
- pc_o  output  DATA_WIDTH  current fetch address (registered)
- pc_valid_o  output  1  pc_o is a valid fetch request
- flush_o  output  1  a redirect was accepted this cycle; fetch drops the in-flight instruction
- misalign_o  output  1  registered one-cycle pulse: branch target was misaligned
- misalign_addr_o  output  DATA_WIDTH  offending target, held until the next misalign event
- halted_o  output  1  state is HALT

## Operation
- States: BOOT, RUN, HALT. pc_valid_o = (state == RUN); halted_o = (state == HALT).
- Reset: state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, flush_o=0, misalign_o=0, misalign_addr_o=0, halted_o=0. Reset overrides all inputs.
- BOOT: one bubble cycle. trap_valid_i loads the trap target. Every other input is ignored. The next state is always RUN.
- RUN, per-cycle priority: trap > branch > halt > advance.
  - Trap: pc <= trap_target_i with bits [log2(INSTR_BYTES)-1:0] forced to 0. flush_o=1. Stay in RUN.
  - Branch, aligned: pc <= branch_target_i. flush_o=1.
  - Branch, misaligned (target mod INSTR_BYTES != 0): target is not loaded. The PC follows the advance rule. misalign_o pulses next cycle, and misalign_addr_o takes the target. flush_o=0.
  - Halt: go to HALT. The PC advances only if pc_ready_i was high this cycle.
  - Advance: when pc_valid_o && pc_ready_i, pc <= pc + INSTR_BYTES, modulo 2^DATA_WIDTH. Otherwise pc holds.
- HALT:
  - Trap: load the aligned target, flush_o=1, go to RUN.
  - resume_i: go to RUN with pc unchanged.
  - branch_valid_i and halt_i are ignored.
- flush_o is combinational from the valid inputs and state. It is never asserted in BOOT, even when a trap loads.
- If a redirect coincides with a handshake, the handshaked PC still counts as issued. flush_o tells fetch to discard it.

## Timing
- pc_o, state, misalign_o and misalign_addr_o are registered. pc_valid_o, halted_o and flush_o decode state or inputs combinationally.
- After rst drops at edge E: BOOT during cycle E. pc_valid_o=1 with pc_o=RESET_VECTOR from cycle E+1.
- Sequential latency: a handshake in cycle N gives pc_o+INSTR_BYTES in cycle N+1. Throughput is one PC per cycle while pc_ready_i is held high.
- Redirect latency: a request in cycle N gives pc_o=target in cycle N+1. pc_valid_o stays high if the state is RUN.
- A misaligned branch in cycle N gives misalign_o=1 in cycle N+1 only.
- Wrap-around: pc_o = 2^DATA_WIDTH - INSTR_BYTES plus a handshake gives 0, with no flag.
- Back-to-back redirects: each accepted cycle loads its own target, and the last one wins.
- Reset asserted mid-operation, in any state: the next edge yields the reset values.

## Test plan
- Reset/boot: rst high for 3 cycles, then low, with pc_ready_i=1. Expected: pc_valid_o=0 for one cycle, then pc_o = 0x0, 0x4, 0x8 on consecutive cycles.
- Backpressure: pc_ready_i=0 for 4 cycles at pc_o=0x10. Expected: pc_o stays 0x10 with pc_valid_o=1, and is 0x14 one cycle after ready returns.
- Priority: trap_target_i=0x8000_0102 and branch_target_i=0x200 asserted in the same cycle. Expected: flush_o=1 that cycle, and pc_o=0x8000_0100 next cycle.
- Misalign: branch_target_i=0x202 with pc_o=0x40 and ready=1. Expected: pc_o=0x44 next cycle, misalign_o=1 for exactly one cycle, misalign_addr_o=0x202.
- Halt/resume:
  - halt_i at pc_o=0x20 with ready=0. Expected: halted_o=1, pc_valid_o=0.
  - A branch during HALT. Expected: ignored.
  - resume_i. Expected: pc_o=0x20 valid.
  - Repeat the sequence, leaving HALT with trap 0x100 instead of resume_i. Expected: pc_o=0x100 in RUN.
- Wrap and reset mid-run: pc_o=0xFFFF_FFFC with ready=1. Expected: pc_o=0x0 next cycle. Then assert rst during a trap. Expected: pc_o=RESET_VECTOR, state BOOT.
